mips_cpu_regfile_sb: RTL
========================

// Module: mips_cpu_regfile_sb
// PURPOSE
//  Parametrised GPR file for the MIPS CPU: NREAD read ports, one write port with partial-load
//  merge (lb/lbu/lh/lhu/lwl/lwr), same-cycle write-to-read bypass and a pending-load scoreboard.
//  Sits between decode (reads, load issue) and writeback. After reset it zeroes the array
//  sequentially so the array can map to RAM.
// PARAMETERS
//  DATA_W  32  register width in bits (multiple of 8, >=32)
//  ADDR_W  5   register select width; array depth = 2**ADDR_W
//  NREAD   2   number of combinational read ports
// PORTS
//  clk        in   1               single clock, all state updates on posedge
//  reset      in   1               synchronous, active-high
//  readreg    in   NREAD*ADDR_W    read selectors; port i = [i*ADDR_W +: ADDR_W]
//  readdata   out  NREAD*DATA_W    read data; port i = [i*DATA_W +: DATA_W]
//  busy       out  NREAD           port i selects a register with a load outstanding
//  writereg   in   ADDR_W          write selector
//  writedata  in   DATA_W          raw memory word or ALU result
//  regwrite   in   1               write enable
//  opcode     in   6               MIPS opcode of the writing instruction
//  byteaddr   in   2               effective-address low bits for partial loads
//  issue_valid in  1               a load is issued to issue_reg this cycle
//  issue_reg  in   ADDR_W          load destination
//  ready      out  1               1 = clear finished, accepting traffic
//  align_err  out  1               one-cycle pulse: misaligned lh/lhu write discarded
//  pend_cnt   out  ADDR_W+1        number of registers with a load outstanding
//  regv0      out  DATA_W          debug copy of register 2, bypassed like a read port
// BEHAVIOUR
//  FSM CLEAR/RUN. reset (any cycle, incl. mid-clear) -> CLEAR, idx=0, pending=0, pend_cnt=0,
//   ready=0, align_err=0. CLEAR writes 0 to reg[idx] each cycle, idx++; after idx=2**ADDR_W-1
//   -> RUN (clear takes 2**ADDR_W cycles). RUN: ready=1, stays until reset.
//  During CLEAR: readdata=0, regv0=0, busy=0; regwrite and issue_valid ignored.
//  Reg 0: reads 0, writes dropped, never pending (issue to 0 ignored).
//  Merge (old=current reg value incl. nothing else; b=byteaddr):
//   lb/lbu: byte b of writedata, sign/zero-extended. lh/lhu: half b[1], b[0] must be 0.
//   lwl: old[DATA_W-1 -: 8*(b+1)] <= writedata[8*(b+1)-1:0], rest of old kept.
//   lwr: old[8*(4-b)-1:0] <= writedata[31:8*b], rest kept. other opcodes: full writedata.
//   lh/lhu with b[0]=1: no write, no pending clear, align_err=1 next cycle (registered).
//  Write commits at posedge; readdata/regv0 combinationally return the merged value when
//   regwrite && writereg==readreg && writereg!=0 (write-first bypass), else array content.
//  Scoreboard: issue_valid sets pending[issue_reg]; a committed write clears pending[writereg].
//   Same reg set and cleared same cycle -> set wins. pend_cnt updated by +1/-1/0 accordingly;
//   re-issue to already-pending reg does not increment. Never exceeds 2**ADDR_W-1.
//  busy[i] = pending[readreg_i] && !(committing write to readreg_i this cycle).
// STRUCTURE
//  mips_cpu_pkg: opcode localparams (OP_LB..OP_LWR), fsm_state_t {CLEAR,RUN}.
//  Sub-module mips_cpu_load_merge: combinational (opcode, byteaddr, old, writedata) ->
//   (merged, wr_en, misaligned); used once, output feeds both array write and bypass.
// TESTING
//  reset 1 cycle -> ready=0 for exactly 32 cycles, then 1; every reg reads 0; reset at
//   idx=10 restarts count at 0.
//  write r5=0xDEADBEEF (op 0x00), read port0 r5 same cycle -> 0xDEADBEEF; r0 write -> reads 0.
//  r6=0x11223344; lb b=3 wd=0x80000000 -> 0xFFFFFF80; lbu b=3 -> 0x00000080;
//   lwl b=1 wd=0xAABBCCDD on r6=0x11223344 -> 0xCCDD3344; lwr b=2 -> 0x1122AABB.
//  lh b=1 -> r unchanged, align_err high one cycle only.
//  issue r8 -> busy on port reading r8, pend_cnt=1; writeback r8 + issue r8 same cycle ->
//   busy stays, pend_cnt=1; writeback r8 alone -> busy=0 that cycle, pend_cnt=0.
//  regv0 tracks r2 incl. bypass: write r2=7 -> regv0=7 same cycle.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU register file.
//   - Opcodes of the load instructions whose writeback needs a merge or an extension.
//   - State type of the register-file clear/run controller.
package mips_cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  typedef enum logic {
    CLEAR,
    RUN
  } fsm_state_t;

endpackage

// File: rtl/mips_cpu_load_merge.sv
// Combinational writeback formatter for partial loads.
//   opcode_i     opcode of the writing instruction
//   byteaddr_i   low two bits of the effective address
//   old_i        current contents of the destination register
//   wdata_i      raw memory word or ALU result
//   merged_o     value to store and to bypass
//   wr_en_o      0 when the write must be discarded
//   misaligned_o lh/lhu with an odd byte address
module mips_cpu_load_merge
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]        opcode_i,
  input  logic [1:0]        byteaddr_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] merged_o,
  output logic              wr_en_o,
  output logic              misaligned_o
);

  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] one;
  logic [DATA_W-1:0] mask;
  int unsigned       nbytes;

  always_comb begin
    byte_v       = wdata_i[{byteaddr_i, 3'b000} +: 8];
    half_v       = wdata_i[{byteaddr_i[1], 4'b0000} +: 16];
    one          = DATA_W'(1);
    mask         = '0;
    nbytes       = 0;
    merged_o     = wdata_i;
    wr_en_o      = 1'b1;
    misaligned_o = 1'b0;

    case (opcode_i)
      OP_LB:  merged_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      OP_LBU: merged_o = {{(DATA_W-8){1'b0}}, byte_v};
      OP_LH, OP_LHU: begin
        if (byteaddr_i[0]) begin
          misaligned_o = 1'b1;
          wr_en_o      = 1'b0;
          merged_o     = old_i;
        end else if (opcode_i == OP_LH) begin
          merged_o = {{(DATA_W-16){half_v[15]}}, half_v};
        end else begin
          merged_o = {{(DATA_W-16){1'b0}}, half_v};
        end
      end
      OP_LWL: begin
        // Low b+1 bytes of the word land in the top b+1 bytes of the register.
        nbytes   = 32'(byteaddr_i) + 32'd1;
        mask     = (one << (8 * nbytes)) - one;
        merged_o = (old_i & ~(mask << (DATA_W - 8 * nbytes)))
                 | ((wdata_i & mask) << (DATA_W - 8 * nbytes));
      end
      OP_LWR: begin
        // Word bytes b..3 land in the low 4-b bytes; mask wraps to all-ones when 4*8 == DATA_W.
        nbytes   = 32'd4 - 32'(byteaddr_i);
        mask     = (one << (8 * nbytes)) - one;
        merged_o = (old_i & ~mask) | ((wdata_i >> (8 * byteaddr_i)) & mask);
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_regfile_sb.sv
// MIPS general-purpose register file with load scoreboard.
//   clk, reset         clock and synchronous active-high reset
//   readreg/readdata   NREAD combinational read ports with write-first bypass
//   busy               per read port: selected register has a load outstanding
//   writereg/writedata/regwrite/opcode/byteaddr  single write port with partial-load merge
//   issue_valid/issue_reg  marks a load destination as pending
//   ready              array clear finished
//   align_err          registered pulse for a discarded misaligned halfword load
//   pend_cnt           number of pending registers
//   regv0              debug view of register 2
// After reset the array is zeroed one entry per cycle so it can map onto a single-port RAM.
module mips_cpu_regfile_sb
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] readreg,
  output logic [NREAD*DATA_W-1:0] readdata,
  output logic [NREAD-1:0]        busy,
  input  logic [ADDR_W-1:0]       writereg,
  input  logic [DATA_W-1:0]       writedata,
  input  logic                    regwrite,
  input  logic [5:0]              opcode,
  input  logic [1:0]              byteaddr,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_reg,
  output logic                    ready,
  output logic                    align_err,
  output logic [ADDR_W:0]         pend_cnt,
  output logic [DATA_W-1:0]       regv0
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  fsm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [Depth-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              align_q, align_d;

  logic              run;
  logic [DATA_W-1:0] merged;
  logic              wr_en;
  logic              misaligned;
  logic              commit;
  logic              set_pend;
  logic              inc, dec;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  mips_cpu_load_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .opcode_i     (opcode),
    .byteaddr_i   (byteaddr),
    .old_i        (mem_q[writereg]),
    .wdata_i      (writedata),
    .merged_o     (merged),
    .wr_en_o      (wr_en),
    .misaligned_o (misaligned)
  );

  assign run      = (state_q == RUN);
  assign commit   = run && regwrite && wr_en && (writereg != '0);
  assign set_pend = run && issue_valid && (issue_reg != '0);

  // ---------------- Clear/run controller ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      CLEAR:   ready = 1'b0;
      RUN:     ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // ---------------- Array: one write port shared by clear and writeback ----------------
  always_comb begin
    mem_we = 1'b0;
    mem_wa = writereg;
    mem_wd = merged;
    if (!run) begin
      mem_we = 1'b1;
      mem_wa = idx_q;
      mem_wd = '0;
    end else if (commit) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // ---------------- Read ports with write-first bypass ----------------
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = readreg[i*ADDR_W +: ADDR_W];
    assign hit = commit && (writereg == ra);
    assign readdata[i*DATA_W +: DATA_W] = (!run || ra == '0) ? '0 :
                                          hit                ? merged : mem_q[ra];
    assign busy[i] = run && pend_q[ra] && !hit;
  end

  assign regv0 = !run                                  ? '0     :
                 (commit && writereg == ADDR_W'(2))     ? merged : mem_q[2];

  // ---------------- Scoreboard ----------------
  always_comb begin
    pend_d = pend_q;
    if (commit)   pend_d[writereg]  = 1'b0;
    if (set_pend) pend_d[issue_reg] = 1'b1;   // set wins over same-cycle clear

    inc = set_pend && !pend_q[issue_reg];
    dec = commit && pend_q[writereg] && !(set_pend && issue_reg == writereg);

    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc) cnt_d = cnt_q - 1'b1;

    align_d = run && regwrite && misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      align_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
    end
  end

  assign pend_cnt  = cnt_q;
  assign align_err = align_q;

endmodule
